// File: rtl/result_bcd_serializer_if.sv
// rtl/result_bcd_serializer_if.sv - request, result and digit-stream bundle for the BCD serializer
interface result_bcd_serializer_if;
    logic        start;
    logic [13:0] value;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [15:0] bcd;
    logic        digit_valid;
    logic [3:0]  digit;
    logic [1:0]  digit_index;
    logic        digit_ready;

    modport master (
        output start, value, digit_ready,
        input  busy, done, overflow, bcd, digit_valid, digit, digit_index
    );

    modport slave (
        input  start, value, digit_ready,
        output busy, done, overflow, bcd, digit_valid, digit, digit_index
    );
endinterface

// File: rtl/result_bcd_serializer.sv
// rtl/result_bcd_serializer.sv - sequential double-dabble binary-to-BCD converter with digit streaming
module result_bcd_serializer (
    input  logic                          clk,
    input  logic                          rst,
    result_bcd_serializer_if.slave        bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, EMIT, DONE} state_t;

    state_t      state_q, state_d;
    // {scratch[15:0], value shifter[13:0]} shift together as one word
    logic [29:0] work_q, work_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] bcd_q, bcd_d;
    logic [1:0]  idx_q, idx_d;
    logic [3:0]  digit_q, digit_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        ovf_q, ovf_d;
    logic        dvalid_q, dvalid_d;

    logic [15:0] adjusted;
    logic [29:0] shifted;

    function automatic logic [15:0] dabble_adjust(input logic [15:0] s);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = (s[i*4 +: 4] >= 4'd5) ? (s[i*4 +: 4] + 4'd3) : s[i*4 +: 4];
        end
        return r;
    endfunction

    function automatic logic [3:0] nibble(input logic [15:0] b, input logic [1:0] i);
        logic [3:0] n;
        case (i)
            2'd3:    n = b[15:12];
            2'd2:    n = b[11:8];
            2'd1:    n = b[7:4];
            default: n = b[3:0];
        endcase
        return n;
    endfunction

    assign adjusted = dabble_adjust(work_q[29:14]);
    assign shifted  = {adjusted, work_q[13:0]} << 1;

    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        bit_cnt_d = bit_cnt_q;
        bcd_d     = bcd_q;
        idx_d     = idx_q;
        digit_d   = digit_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ovf_d     = ovf_q;
        dvalid_d  = dvalid_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    work_d    = {16'h0000, bus.value};
                    bit_cnt_d = 4'd0;
                    busy_d    = 1'b1;
                    ovf_d     = (bus.value > 14'd9999);
                    if (bus.value > 14'd9999) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end

            SHIFT: begin
                work_d    = shifted;
                bit_cnt_d = bit_cnt_q + 4'd1;
                if (bit_cnt_q == 4'd13) begin
                    state_d  = EMIT;
                    bcd_d    = shifted[29:14];
                    idx_d    = 2'd3;
                    digit_d  = shifted[29:26];
                    dvalid_d = 1'b1;
                end
            end

            EMIT: begin
                if (bus.digit_ready) begin
                    if (idx_q == 2'd0) begin
                        state_d  = DONE;
                        dvalid_d = 1'b0;
                        done_d   = 1'b1;
                    end else begin
                        idx_d   = idx_q - 2'd1;
                        digit_d = nibble(bcd_q, idx_q - 2'd1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            work_q    <= '0;
            bit_cnt_q <= '0;
            bcd_q     <= 16'h0000;
            idx_q     <= 2'd0;
            digit_q   <= 4'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            dvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            work_q    <= work_d;
            bit_cnt_q <= bit_cnt_d;
            bcd_q     <= bcd_d;
            idx_q     <= idx_d;
            digit_q   <= digit_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            dvalid_q  <= dvalid_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.overflow    = ovf_q;
    assign bus.bcd         = bcd_q;
    assign bus.digit_valid = dvalid_q;
    assign bus.digit       = digit_q;
    assign bus.digit_index = idx_q;
endmodule

// File: tb/tb_result_bcd_serializer.sv
// tb/tb_result_bcd_serializer.sv - directed table-driven bench for result_bcd_serializer
module tb_result_bcd_serializer;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    result_bcd_serializer_if bus ();

    result_bcd_serializer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] value;
        int          stall;
        int          poke_cyc;
        logic [13:0] poke_val;
        logic [15:0] exp_bcd;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"},        int'(bus.busy), 0);
        chk({tag, "_done"},        int'(bus.done), 0);
        chk({tag, "_overflow"},    int'(bus.overflow), 0);
        chk({tag, "_bcd"},         int'(bus.bcd), 0);
        chk({tag, "_digit_valid"}, int'(bus.digit_valid), 0);
        chk({tag, "_digit"},       int'(bus.digit), 0);
        chk({tag, "_digit_index"}, int'(bus.digit_index), 0);
    endtask

    // Called at a negedge with the block idle; start is sampled at the following posedge (cycle N).
    task automatic run_req(input vec_t t);
        int          c;
        int          ndig;
        int          stall_left;
        int          first_xfer;
        int          done_cyc;
        logic [15:0] tmp;
        bus.value       = t.value;
        bus.start       = 1'b1;
        bus.digit_ready = 1'b0;
        @(negedge clk);
        bus.start  = 1'b0;
        c          = 1;
        ndig       = 0;
        stall_left = t.stall;
        first_xfer = -1;
        done_cyc   = -1;
        chk("busy_after_start", int'(bus.busy), 1);
        while (c < 120 && done_cyc < 0) begin
            if (c == t.poke_cyc) begin
                bus.start = 1'b1;
                bus.value = t.poke_val;
            end else begin
                bus.start = 1'b0;
            end
            bus.digit_ready = 1'b0;
            if (bus.digit_valid) begin
                if (ndig >= 4) begin
                    chk("extra_digit_valid", int'(bus.digit_valid), 0);
                end else begin
                    tmp = t.exp_bcd >> (4 * (3 - ndig));
                    chk("digit", int'(bus.digit), int'(tmp[3:0]));
                    chk("digit_index", int'(bus.digit_index), 3 - ndig);
                    if (stall_left > 0) begin
                        stall_left--;
                    end else begin
                        bus.digit_ready = 1'b1;
                        if (first_xfer < 0) first_xfer = c;
                        ndig++;
                        stall_left = t.stall;
                    end
                end
            end
            if (bus.done) done_cyc = c;
            @(negedge clk);
            c++;
        end
        bus.start       = 1'b0;
        bus.digit_ready = 1'b0;
        chk("done_cycle",  done_cyc,   t.exp_ovf ? 1 : 19 + 4 * t.stall);
        chk("first_xfer",  first_xfer, t.exp_ovf ? -1 : 15 + t.stall);
        chk("transfers",   ndig,       t.exp_ovf ? 0 : 4);
        chk("bcd",         int'(bus.bcd), int'(t.exp_bcd));
        chk("overflow",    int'(bus.overflow), int'(t.exp_ovf));
        chk("done_pulse_one_cycle", int'(bus.done), 0);
        chk("idle_busy",   int'(bus.busy), 0);
        chk("idle_dvalid", int'(bus.digit_valid), 0);
    endtask

    initial begin
        vec_t rv;
        int   seen_done;
        int   seen_valid;
        total = 0;
        bad   = 0;

        vecs[0] = '{14'd1234,  0, 0, 14'd0,  16'h1234, 1'b0};
        vecs[1] = '{14'd7,     0, 0, 14'd0,  16'h0007, 1'b0};
        vecs[2] = '{14'd9999,  3, 0, 14'd0,  16'h9999, 1'b0};
        vecs[3] = '{14'd10000, 0, 0, 14'd0,  16'h9999, 1'b1};
        vecs[4] = '{14'd500,   0, 5, 14'd42, 16'h0500, 1'b0};
        vecs[5] = '{14'd42,    0, 0, 14'd0,  16'h0042, 1'b0};
        vecs[6] = '{14'd0,     0, 0, 14'd0,  16'h0000, 1'b0};
        vecs[7] = '{14'd16383, 0, 0, 14'd0,  16'h0000, 1'b1};
        vecs[8] = '{14'd1000,  0, 0, 14'd0,  16'h1000, 1'b0};

        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.value       = 14'd0;
        bus.digit_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            run_req(vecs[i]);
        end

        // Reset mid-conversion: start at N, reset sampled at the edge ending cycle N+8.
        bus.value = 14'd1234;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("abort");
        bus.digit_ready = 1'b1;
        seen_done  = 0;
        seen_valid = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.done) seen_done = 1;
            if (bus.digit_valid) seen_valid = 1;
        end
        bus.digit_ready = 1'b0;
        chk("abort_no_done",   seen_done, 0);
        chk("abort_no_digits", seen_valid, 0);

        rv = '{14'd305, 0, 0, 14'd0, 16'h0305, 1'b0};
        run_req(rv);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/result_bcd_serializer.md
RESULT_BCD_SERIALIZER -- requirements
Module: result_bcd_serializer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 start  input  1  request to convert `value`; honoured only in IDLE.
REQ-005 value  input  14  unsigned binary result; legal range 0..9999.
REQ-006 busy  output  1  high in every state except IDLE.
REQ-007 done  output  1  one-cycle pulse when a request completes.
REQ-008 overflow  output  1  high when the last captured value exceeded 9999; valid from `done` until the next accepted start.
REQ-009 bcd  output  16  4-digit BCD of the last converted value; [15:12] thousands ... [3:0] units.
REQ-010 digit_valid  output  1  a digit is presented on `digit` and `digit_index`.
REQ-011 digit  output  4  BCD digit being presented.
REQ-012 digit_index  output  2  position of `digit`: 3 = thousands ... 0 = units.
REQ-013 digit_ready  input  1  consumer accepts the digit when high together with digit_valid.

Function
REQ-014 The block SHALL implement the states IDLE, SHIFT, EMIT and DONE.
REQ-015 IDLE: when start=1, the block SHALL capture `value`, clear `overflow`, and move to SHIFT if value<=9999, otherwise move to DONE.
REQ-016 start SHALL be ignored in every state other than IDLE; no request is queued.
REQ-017 SHIFT SHALL run sequential double-dabble for exactly 14 cycles, processing one value bit per cycle, MSB first.
REQ-018 In each SHIFT cycle, every 4-bit scratch nibble >=5 SHALL first have 3 added; the 16-bit scratch and the value shifter SHALL then shift left by one together.
REQ-019 `bcd` SHALL keep its previous contents during SHIFT and load the final scratch on the SHIFT->EMIT transition.
REQ-020 EMIT SHALL present digits in the order index 3, 2, 1, 0.
  - digit = bcd nibble selected by digit_index.
  - digit_valid is held high continuously in EMIT.
REQ-021 A digit SHALL be transferred only on a cycle where digit_valid=1 and digit_ready=1; digit and digit_index SHALL stay stable while digit_ready=0.
REQ-022 Leading zeros SHALL be emitted; exactly 4 transfers occur per in-range request.
REQ-023 After the index-0 transfer, the block SHALL enter DONE.
REQ-024 DONE SHALL last one cycle, asserting done=1, and then return to IDLE.
REQ-025 Latency with digit_ready tied high:
  - start sampled at cycle N;
  - SHIFT occupies N+1..N+14;
  - digits transfer at N+15..N+18;
  - done=1 at N+19;
  - start is accepted again at N+20.
REQ-026 Overflow path: value>9999 SHALL produce overflow=1, no digit transfers, `bcd` unchanged, and done=1 at N+1.
REQ-027 digit_valid SHALL be 0 outside EMIT.

Reset
REQ-028 On rst=1 at a clock edge, the block SHALL enter IDLE.
REQ-029 At that edge, busy, done, overflow, digit_valid, digit and digit_index SHALL become 0, and bcd SHALL become 16'h0000.
REQ-030 Reset SHALL have priority over start and over any in-progress conversion or emission.
REQ-031 Reset during SHIFT or EMIT SHALL abort the request without a done pulse and without further digit transfers.

Verification
REQ-032 The bench SHALL cover the following directed scenarios:
  - value=1234, start pulse, digit_ready=1 -> digits 1,2,3,4 at indices 3,2,1,0 on cycles N+15..N+18; bcd=16'h1234; done at N+19; overflow=0.
  - value=0007, digit_ready=1 -> digits 0,0,0,7 are emitted; bcd=16'h0007.
  - value=9999, digit_ready low for 3 cycles at each index -> each digit is held stable until accepted; 4 transfers total; done arrives 12 cycles later than nominal.
  - value=10000 -> overflow=1 and done at N+1; no digit_valid; bcd keeps its prior value.
  - Second start during SHIFT with value=42 after a first value=500 -> only 500 is converted (16'h0500); a new start at N+20 converts 42.
  - rst asserted at N+8 of a conversion -> next cycle all outputs are 0 and state is IDLE; no done pulse.
